// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access-width codes and byte-enable generation.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_RSVD = 2'b10,
        WIDTH_WORD = 2'b11
    } width_e;

    localparam int unsigned NB_LANES = 4;

    // Reserved width code behaves as a full word.
    function automatic logic [NB_LANES-1:0] byte_enable(input width_e w, input logic [1:0] lane);
        case (w)
            WIDTH_BYTE: return 4'b0001 << lane;
            WIDTH_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-organised data memory: two asynchronous read ports, one byte-enabled synchronous write.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int unsigned NB_REG      = 32,
    parameter int unsigned NB_MEM_ADDR = 8
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [NB_LANES-1:0]    i_be,
    input  logic [NB_MEM_ADDR-1:0] i_addr_a,
    input  logic [NB_REG-1:0]      i_wdata,
    output logic [NB_REG-1:0]      o_data_a,
    input  logic [NB_MEM_ADDR-1:0] i_addr_b,
    output logic [NB_REG-1:0]      o_data_b
);

    logic [NB_REG-1:0] mem_q [2**NB_MEM_ADDR];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < NB_LANES; i++) begin
                if (i_be[i]) mem_q[i_addr_a][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_data_a = mem_q[i_addr_a];
    assign o_data_b = mem_q[i_addr_b];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: store lane steering, load formatting, and the MEM/WB register bank.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned NB_REG      = 32,
    parameter int unsigned NB_MEM_ADDR = 8,
    parameter int unsigned NB_RD       = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_stall,
    input  logic [NB_REG-1:0]      i_alu_result,
    input  logic [NB_REG-1:0]      i_write_data,
    input  logic [NB_REG-1:0]      i_pcplus8,
    input  logic [NB_RD-1:0]       i_rd_addr,
    input  logic                   i_MemRead,
    input  logic                   i_MemWrite,
    input  logic [1:0]             i_width,
    input  logic                   i_unsigned,
    input  logic                   i_MemToReg,
    input  logic                   i_RegWrite,
    input  logic                   i_isJal,
    input  logic [NB_MEM_ADDR-1:0] i_dbg_addr,
    output logic [NB_REG-1:0]      o_dbg_data,
    output logic [NB_REG-1:0]      o_alu_result,
    output logic [NB_REG-1:0]      o_data_from_mem,
    output logic [NB_REG-1:0]      o_pcplus8,
    output logic [NB_RD-1:0]       o_rd_addr,
    output logic                   o_MemToReg,
    output logic                   o_RegWrite,
    output logic                   o_isJal,
    output logic                   o_misaligned
);

    width_e                   width;
    logic [1:0]               lane;
    logic [NB_MEM_ADDR-1:0]   word_idx;
    logic                     misaligned;
    logic                     mem_we;
    logic [NB_LANES-1:0]      be;
    logic [NB_REG-1:0]        wdata;
    logic [NB_REG-1:0]        rdata;
    logic [7:0]               sel_byte;
    logic [15:0]              sel_half;
    logic [NB_REG-1:0]        load_fmt;

    logic [NB_REG-1:0] alu_q, alu_d, data_q, data_d, pc8_q, pc8_d;
    logic [NB_RD-1:0]  rd_q, rd_d;
    logic              m2r_q, m2r_d, rw_q, rw_d, jal_q, jal_d, mis_q, mis_d;

    assign width    = width_e'(i_width);
    assign lane     = i_alu_result[1:0];
    assign word_idx = i_alu_result[NB_MEM_ADDR+1:2];

    always_comb begin
        misaligned = 1'b0;
        if (i_MemRead | i_MemWrite) begin
            case (width)
                WIDTH_BYTE: misaligned = 1'b0;
                WIDTH_HALF: misaligned = lane[0];
                default:    misaligned = |lane;
            endcase
        end
    end

    assign mem_we = i_MemWrite & ~misaligned & ~i_stall;
    assign be     = byte_enable(width, lane);

    always_comb begin
        case (width)
            WIDTH_BYTE: wdata = {NB_LANES{i_write_data[7:0]}};
            WIDTH_HALF: wdata = {(NB_LANES/2){i_write_data[15:0]}};
            default:    wdata = i_write_data;
        endcase
    end

    data_memory #(
        .NB_REG      (NB_REG),
        .NB_MEM_ADDR (NB_MEM_ADDR)
    ) u_dmem (
        .i_clk    (i_clk),
        .i_we     (mem_we),
        .i_be     (be),
        .i_addr_a (word_idx),
        .i_wdata  (wdata),
        .o_data_a (rdata),
        .i_addr_b (i_dbg_addr),
        .o_data_b (o_dbg_data)
    );

    always_comb begin
        case (lane)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = lane[1] ? rdata[31:16] : rdata[15:0];
        case (width)
            WIDTH_BYTE: load_fmt = {{(NB_REG-8){sel_byte[7] & ~i_unsigned}}, sel_byte};
            WIDTH_HALF: load_fmt = {{(NB_REG-16){sel_half[15] & ~i_unsigned}}, sel_half};
            default:    load_fmt = rdata;
        endcase
    end

    always_comb begin
        alu_d  = alu_q;
        data_d = data_q;
        pc8_d  = pc8_q;
        rd_d   = rd_q;
        m2r_d  = m2r_q;
        rw_d   = rw_q;
        jal_d  = jal_q;
        mis_d  = mis_q;
        if (!i_stall) begin
            alu_d  = i_alu_result;
            data_d = (i_MemRead && !misaligned) ? load_fmt : '0;
            pc8_d  = i_pcplus8;
            rd_d   = i_rd_addr;
            m2r_d  = i_MemToReg;
            rw_d   = i_RegWrite & ~misaligned;
            jal_d  = i_isJal;
            mis_d  = misaligned;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alu_q  <= '0;
            data_q <= '0;
            pc8_q  <= '0;
            rd_q   <= '0;
            m2r_q  <= 1'b0;
            rw_q   <= 1'b0;
            jal_q  <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            alu_q  <= alu_d;
            data_q <= data_d;
            pc8_q  <= pc8_d;
            rd_q   <= rd_d;
            m2r_q  <= m2r_d;
            rw_q   <= rw_d;
            jal_q  <= jal_d;
            mis_q  <= mis_d;
        end
    end

    assign o_alu_result    = alu_q;
    assign o_data_from_mem = data_q;
    assign o_pcplus8       = pc8_q;
    assign o_rd_addr       = rd_q;
    assign o_MemToReg      = m2r_q;
    assign o_RegWrite      = rw_q;
    assign o_isJal         = jal_q;
    assign o_misaligned    = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-addressed reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] alu_result = '0, write_data = '0, pcplus8 = '0;
    logic [4:0]  rd_addr = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, uns = 1'b0;
    logic [1:0]  width = 2'b11;
    logic        mem_to_reg = 1'b0, reg_write = 1'b0, is_jal = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_data, o_alu, o_data, o_pc8;
    logic [4:0]  o_rd;
    logic        o_m2r, o_rw, o_jal, o_mis;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] ref_mem [256];
    bit          known   [256];
    logic [31:0] e_alu, e_data, e_pc8;
    logic [4:0]  e_rd;
    logic        e_m2r, e_rw, e_jal, e_mis;

    mem_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .i_alu_result(alu_result), .i_write_data(write_data), .i_pcplus8(pcplus8),
        .i_rd_addr(rd_addr), .i_MemRead(mem_read), .i_MemWrite(mem_write),
        .i_width(width), .i_unsigned(uns), .i_MemToReg(mem_to_reg),
        .i_RegWrite(reg_write), .i_isJal(is_jal), .i_dbg_addr(dbg_addr),
        .o_dbg_data(dbg_data), .o_alu_result(o_alu), .o_data_from_mem(o_data),
        .o_pcplus8(o_pc8), .o_rd_addr(o_rd), .o_MemToReg(o_m2r),
        .o_RegWrite(o_rw), .o_isJal(o_jal), .o_misaligned(o_mis)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".alu"},  o_alu,  e_alu);
        check({tag, ".data"}, o_data, e_data);
        check({tag, ".pc8"},  o_pc8,  e_pc8);
        check({tag, ".rd"},   {27'd0, o_rd}, {27'd0, e_rd});
        check({tag, ".ctrl"}, {28'd0, o_m2r, o_rw, o_jal, o_mis},
                              {28'd0, e_m2r, e_rw, e_jal, e_mis});
    endtask

    // Model: addresses are byte addresses; access size in bytes, alignment by modulo.
    task automatic model(input logic st, input logic mr, input logic mw, input logic [1:0] w,
                         input logic u, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc8, input logic [4:0] rd,
                         input logic m2r, input logic rw, input logic jal);
        int unsigned size, lane, idx;
        bit          mis;
        logic [63:0] val, mask;
        if (st) return;
        size = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        lane = a % 4;
        idx  = (a / 4) % 256;
        mis  = (mr || mw) && ((a % size) != 0);
        val  = '0;
        if (mr && !mis) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            val  = ({32'd0, ref_mem[idx]} >> (8 * lane)) & mask;
            if (!u && size < 4 && val[8*size-1]) val = val | ~mask;
        end
        if (mw && !mis) begin
            for (int b = 0; b < int'(size); b++)
                ref_mem[idx][8*(int'(lane)+b) +: 8] = wd[8*b +: 8];
            if (size == 4) known[idx] = 1'b1;
        end
        e_alu  = a;
        e_data = val[31:0];
        e_pc8  = pc8;
        e_rd   = rd;
        e_m2r  = m2r;
        e_rw   = rw && !mis;
        e_jal  = jal;
        e_mis  = mis;
    endtask

    task automatic step(input string tag, input logic st, input logic mr, input logic mw,
                        input logic [1:0] w, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] pc8, input logic [4:0] rd,
                        input logic m2r, input logic rw, input logic jal, input logic [7:0] dbg,
                        input bit chk);
        @(negedge clk);
        stall = st; mem_read = mr; mem_write = mw; width = w; uns = u;
        alu_result = a; write_data = wd; pcplus8 = pc8; rd_addr = rd;
        mem_to_reg = m2r; reg_write = rw; is_jal = jal; dbg_addr = dbg;
        #1;
        if (chk && known[dbg]) check({tag, ".dbg"}, dbg_data, ref_mem[dbg]);
        model(st, mr, mw, w, u, a, wd, pc8, rd, m2r, rw, jal);
        @(posedge clk);
        #1;
        if (chk) check_outputs(tag);
    endtask

    task automatic load(input string tag, input logic [1:0] w, input logic u, input logic [31:0] a);
        step(tag, 1'b0, 1'b1, 1'b0, w, u, a, 32'd0, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic store(input string tag, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] wd, input bit chk);
        step(tag, 1'b0, 1'b0, 1'b1, w, 1'b0, a, wd, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, chk);
    endtask

    initial begin
        logic [31:0] dbg_before;
        e_alu = '0; e_data = '0; e_pc8 = '0; e_rd = '0;
        e_m2r = 1'b0; e_rw = 1'b0; e_jal = 1'b0; e_mis = 1'b0;
        for (int i = 0; i < 256; i++) begin
            known[i] = 1'b0;
            ref_mem[i] = '0;
        end

        #2;
        check_outputs("reset_init");
        #10 rst_n = 1'b1;

        for (int i = 0; i < 256; i++)
            store("fill", 2'b11, 32'(i) << 2, $urandom(), 1'b0);

        // Reset mid-cycle after driving nonzero outputs.
        step("jal_pre", 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'hA5A5_0004, 32'd0, 32'h0000_1234,
             5'd7, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        e_alu = '0; e_data = '0; e_pc8 = '0; e_rd = '0;
        e_m2r = 1'b0; e_rw = 1'b0; e_jal = 1'b0; e_mis = 1'b0;
        check_outputs("reset_mid");
        @(negedge clk) rst_n = 1'b1;

        store("sw_beef", 2'b11, 32'h10, 32'hDEAD_BEEF, 1'b1);
        load("lw_beef", 2'b11, 1'b0, 32'h10);
        check("lw_beef_const", o_data, 32'hDEAD_BEEF);
        store("sb_80", 2'b00, 32'h13, 32'h0000_0080, 1'b1);
        load("lb_80", 2'b00, 1'b0, 32'h13);
        check("lb_const", o_data, 32'hFFFF_FF80);
        load("lbu_80", 2'b00, 1'b1, 32'h13);
        check("lbu_const", o_data, 32'h0000_0080);
        load("lw_80", 2'b11, 1'b0, 32'h10);
        check("lw_merged_const", o_data, 32'h80AD_BEEF);
        load("lh_mis", 2'b01, 1'b0, 32'h11);
        check("lh_mis_flag", {31'd0, o_mis}, 32'd1);
        check("lh_mis_rw", {31'd0, o_rw}, 32'd0);
        check("lh_mis_data", o_data, 32'd0);
        store("sh_mis", 2'b01, 32'h11, 32'h0000_FFFF, 1'b1);
        load("lw_after_mis", 2'b11, 1'b0, 32'h10);
        check("lw_after_mis_const", o_data, 32'h80AD_BEEF);

        // Stalled store must neither write nor move the outputs.
        dbg_before = ref_mem[8];
        for (int i = 0; i < 3; i++) begin
            step("stall_sw", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_5678, 32'h44,
                 5'd9, 1'b0, 1'b0, 1'b0, 8'd8, 1'b1);
            check("stall_dbg_hold", dbg_data, dbg_before);
        end
        step("stall_rel", 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_5678, 32'h44,
             5'd9, 1'b0, 1'b0, 1'b0, 8'd8, 1'b1);
        check("stall_rel_dbg", dbg_data, 32'h1234_5678);

        step("jal", 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0000_0048, 5'd31,
             1'b0, 1'b1, 1'b1, 8'd8, 1'b1);
        check("jal_pc8_const", o_pc8, 32'h0000_0048);
        check("jal_rd_const", {27'd0, o_rd}, 32'd31);

        step("rdwr", 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, 5'd3,
             1'b1, 1'b1, 1'b0, 8'd8, 1'b1);
        check("rdwr_old_const", o_data, 32'h1234_5678);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [1:0]  op;
            a  = $urandom();
            op = 2'($urandom_range(0, 3));
            step("rand", ($urandom_range(0, 7) == 0), op[0], op[1],
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom(),
                 $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
